zap_ifetch_port: RTL

//  Instruction-side bus initiator feeding zap_fetch_main. Generates sequential word fetches on a

---
 rtl/zap_ifetch_port.sv | 131 +++++++++++++
 1 files changed

// File: rtl/zap_ifetch_port.sv
//==============================================================================
// zap_ifetch_port: Wishbone-classic instruction fetch initiator with output FIFO
// Revision: 1.0
//==============================================================================
`default_nettype none

module zap_ifetch_port #(
  parameter logic [31:0] RESET_VECTOR = 32'd0,
  parameter int          DEPTH        = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic [31:0] o_instr_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic          cyc;
  logic [31:0]   adr;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_after_pop;
  logic [31:0]   mem_instr [DEPTH];
  logic          mem_abort [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic pop, term, push, issue;

  assign count_after_pop = count - {{AW{1'b0}}, pop};

  always_comb begin
    pop       = (count != '0) && !i_stall;
    term      = cyc && (i_wb_ack || i_wb_err);
    push      = 1'b0;
    issue     = 1'b0;
    state_nxt = state;
    if (i_redirect) begin
      // An in-flight transfer must complete on the bus even though its data is unwanted.
      state_nxt = (cyc && !term) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (term) begin
            push = 1'b1;
            if (i_wb_err) state_nxt = SLEEP;
          end else if (!cyc && (count_after_pop < FULL)) begin
            issue = 1'b1;
          end
        end
        DRAIN:   if (term) state_nxt = FETCH;
        SLEEP:   state_nxt = SLEEP;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= FETCH;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc <= RESET_VECTOR;
      cyc      <= 1'b0;
      adr      <= 32'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (term) begin
        cyc <= 1'b0;
      end else if (issue) begin
        cyc <= 1'b1;
        adr <= fetch_pc;
      end
      if (i_redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (push && !i_wb_err) fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Storage needs no reset: every read is qualified by a non-zero count.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset && !i_redirect) begin
      mem_instr[wr_ptr] <= i_wb_err ? 32'd0 : i_wb_dat;
      mem_abort[wr_ptr] <= i_wb_err;
      mem_pc[wr_ptr]    <= adr;
    end
  end

  assign o_valid       = (count != '0);
  assign o_instr_abort = o_valid && mem_abort[rd_ptr];
  assign o_instruction = (o_valid && !mem_abort[rd_ptr]) ? mem_instr[rd_ptr] : 32'd0;
  assign o_instr_pc    = o_valid ? mem_pc[rd_ptr] : 32'd0;
  assign o_wb_cyc      = cyc;
  assign o_wb_stb      = cyc;
  assign o_wb_adr      = adr;

endmodule

`default_nettype wire
